// File: rtl/rot_pkg.sv
// Shared fixed-point definitions for the rotation datapath.
// Provides the Q16.16 format constants, the accumulator width used by the
// multiply-accumulate unit, the transpose-multiply state type, and the
// round-half-up / saturate helper that turns an accumulator into a Q value.
package rot_pkg;

   localparam int MAT_SIZE  = 3;
   localparam int Q_WIDTH   = 32;
   localparam int Q_FRAC    = 16;
   localparam int ACC_WIDTH = 66;

   localparam logic signed [Q_WIDTH-1:0] Q_ONE = 32'sh0001_0000;
   localparam logic signed [Q_WIDTH-1:0] Q_MAX = 32'sh7FFF_FFFF;
   localparam logic signed [Q_WIDTH-1:0] Q_MIN = 32'sh8000_0000;

   localparam logic signed [ACC_WIDTH-1:0] ACC_ONE = 66'sd1;
   localparam logic signed [ACC_WIDTH-1:0] SAT_HI  = 66'sd2147483647;
   localparam logic signed [ACC_WIDTH-1:0] SAT_LO  = -66'sd2147483648;

   typedef enum logic [1:0] {IDLE, MAC, DONE} mtv_state_t;

   // Adds half an output LSB, then arithmetic-shifts: floor(x + 0.5), i.e.
   // ties round toward +infinity. The shifted value is clamped to the Q range.
   function automatic logic signed [Q_WIDTH-1:0] q_round_sat(
      input logic signed [ACC_WIDTH-1:0] acc,
      input int                          frac
   );
      logic signed [ACC_WIDTH-1:0] s;
      s = (acc + (ACC_ONE <<< (frac - 1))) >>> frac;
      if (s > SAT_HI) begin
         q_round_sat = Q_MAX;
      end else if (s < SAT_LO) begin
         q_round_sat = Q_MIN;
      end else begin
         q_round_sat = s[Q_WIDTH-1:0];
      end
   endfunction

endpackage

// File: rtl/q_mac.sv
// Signed Q16.16 multiply-accumulate unit.
// Ports:
//   clk_in  clock, rising edge
//   rst_in  synchronous active-low reset, clears the accumulator
//   en      fold the current product into the accumulator this edge
//   clr     the current product closes a dot product; restart from zero after it
//   a, b    signed 32-bit operands
//   acc     running sum INCLUDING the product now on a*b, so the caller can
//           round a finished dot product on the same edge as its last term
module q_mac
   import rot_pkg::*;
(
   input  logic                          clk_in,
   input  logic                          rst_in,
   input  logic                          clr,
   input  logic                          en,
   input  logic signed [Q_WIDTH-1:0]     a,
   input  logic signed [Q_WIDTH-1:0]     b,
   output logic signed [ACC_WIDTH-1:0]   acc
);

   logic signed [2*Q_WIDTH-1:0] prod;
   logic signed [ACC_WIDTH-1:0] acc_q;
   logic signed [ACC_WIDTH-1:0] acc_d;

   assign prod = a * b;
   assign acc  = acc_q + $signed({{(ACC_WIDTH-2*Q_WIDTH){prod[2*Q_WIDTH-1]}}, prod});

   always_comb begin
      acc_d = acc_q;
      if (en) begin
         acc_d = clr ? '0 : acc;
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/mtvmul_seq.sv
// Sequential 3x3 transpose-matrix times vector: vec_out[i] = col_i . vec_b.
// One shared MAC walks the 9 products, one per cycle, in column-major order.
// Ports:
//   clk_in, rst_in          clock; synchronous active-low reset
//   valid_in / ready_out    operand handshake (ready only while idle)
//   mat_c1..mat_c3, vec_b   matrix columns and input vector, signed Q16.16
//   vec_out                 result vector, signed Q16.16, rounded and saturated
//   valid_out / ready_in    result handshake; result held until accepted
module mtvmul_seq
   import rot_pkg::*;
#(
   parameter int WIDTH     = Q_WIDTH,
   parameter int FRAC_BITS = Q_FRAC
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    valid_in,
   output logic                    ready_out,
   input  logic signed [WIDTH-1:0] mat_c1  [MAT_SIZE],
   input  logic signed [WIDTH-1:0] mat_c2  [MAT_SIZE],
   input  logic signed [WIDTH-1:0] mat_c3  [MAT_SIZE],
   input  logic signed [WIDTH-1:0] vec_b   [MAT_SIZE],
   output logic signed [WIDTH-1:0] vec_out [MAT_SIZE],
   output logic                    valid_out,
   input  logic                    ready_in
);

   mtv_state_t state_q, state_d;
   logic [1:0] i_q, i_d;   // output element / matrix column
   logic [1:0] j_q, j_d;   // term within the dot product

   logic signed [WIDTH-1:0] col_q [MAT_SIZE][MAT_SIZE];
   logic signed [WIDTH-1:0] b_q   [MAT_SIZE];
   logic signed [WIDTH-1:0] vec_q [MAT_SIZE];

   logic                        mac_en;
   logic                        mac_clr;
   logic signed [ACC_WIDTH-1:0] mac_acc;

   assign mac_en  = (state_q == MAC);
   assign mac_clr = (j_q == 2'd2);

   q_mac u_mac (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .clr    (mac_clr),
      .en     (mac_en),
      .a      (col_q[i_q][j_q]),
      .b      (b_q[j_q]),
      .acc    (mac_acc)
   );

   always_comb begin
      state_d   = state_q;
      i_d       = i_q;
      j_d       = j_q;
      ready_out = (state_q == IDLE);
      valid_out = (state_q == DONE);
      case (state_q)
         IDLE: begin
            if (valid_in) begin
               state_d = MAC;
               i_d     = 2'd0;
               j_d     = 2'd0;
            end
         end
         MAC: begin
            if (j_q == 2'd2) begin
               j_d = 2'd0;
               if (i_q == 2'd2) begin
                  i_d     = 2'd0;
                  state_d = DONE;
               end else begin
                  i_d = i_q + 2'd1;
               end
            end else begin
               j_d = j_q + 2'd1;
            end
         end
         DONE: begin
            if (ready_in) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q <= IDLE;
         i_q     <= 2'd0;
         j_q     <= 2'd0;
         for (int n = 0; n < MAT_SIZE; n++) begin
            vec_q[n] <= '0;
         end
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         // Last term of column i: mac_acc already includes it.
         if (state_q == MAC && j_q == 2'd2) begin
            vec_q[i_q] <= q_round_sat(mac_acc, FRAC_BITS);
         end
      end
   end

   // Operands are only ever overwritten on the accept edge, so they need no reset.
   always_ff @(posedge clk_in) begin
      if (state_q == IDLE && valid_in) begin
         for (int n = 0; n < MAT_SIZE; n++) begin
            col_q[0][n] <= mat_c1[n];
            col_q[1][n] <= mat_c2[n];
            col_q[2][n] <= mat_c3[n];
            b_q[n]      <= vec_b[n];
         end
      end
   end

   assign vec_out = vec_q;

endmodule
